// File: rtl/crc_ctrl.sv
// Frame sequencer around the nibble CRC step block: runs a start/length frame
// through crc_eval beat by beat and reports the final CRC or a check verdict.

module crc_eval #(
  parameter int WCODE = 4,
  parameter int WPOLY = 3
) (
  input  logic [WCODE-1:0] i_data,
  input  logic [WPOLY-2:0] i_crc,
  input  logic [WPOLY-1:0] i_poly,
  output logic [WPOLY-2:0] o_crc
);
  localparam int TW = WCODE + WPOLY - 1;

  logic [TW-1:0] tmp;
  logic [TW-1:0] p;

  // Division is driven by the original data bits, not the running remainder.
  always_comb begin
    tmp = {i_data, i_crc};
    p   = {i_poly, {(WCODE-1){1'b0}}};
    for (int unsigned k = 0; k < WCODE; k++) begin
      if (i_data[WCODE-1-k]) tmp = tmp ^ p;
      p = p >> 1;
    end
    o_crc = tmp[WPOLY-2:0];
  end
endmodule

module crc_ctrl #(
  parameter int WCODE  = 4,
  parameter int WPOLY  = 3,
  parameter int MAXLEN = 16,
  parameter int LW     = $clog2(MAXLEN + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_mode,
  input  logic [WPOLY-1:0] i_poly,
  input  logic [LW-1:0]    i_len,
  input  logic [WCODE-1:0] i_data,
  input  logic             i_valid,
  output logic             o_ready,
  output logic             o_busy,
  output logic [WPOLY-2:0] o_crc,
  output logic             o_done,
  output logic             o_err
);
  localparam logic [LW-1:0] MAXLEN_L = LW'(MAXLEN);
  localparam logic [LW-1:0] ONE_L    = LW'(1);

  typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_t;

  state_t           state;
  logic [WPOLY-2:0] crc_reg;
  logic [WPOLY-2:0] step_crc;
  logic [LW-1:0]    cnt;
  logic [WPOLY-1:0] poly;
  logic             mode;
  logic             len_ok;

  assign len_ok = (i_len != '0) && (i_len <= MAXLEN_L);

  crc_eval #(.WCODE(WCODE), .WPOLY(WPOLY)) u_eval (
    .i_data (i_data),
    .i_crc  (crc_reg),
    .i_poly (poly),
    .o_crc  (step_crc)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      crc_reg <= '0;
      cnt     <= '0;
      poly    <= '0;
      mode    <= 1'b0;
      o_ready <= 1'b0;
      o_busy  <= 1'b0;
      o_crc   <= '0;
      o_done  <= 1'b0;
      o_err   <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            o_busy  <= 1'b1;
            crc_reg <= '0;
            if (len_ok) begin
              cnt     <= i_len;
              poly    <= i_poly;
              mode    <= i_mode;
              o_err   <= 1'b0;
              o_ready <= 1'b1;
              state   <= RUN;
            end else begin
              o_err  <= 1'b1;
              o_crc  <= '0;
              o_done <= 1'b1;
              state  <= DONE;
            end
          end
        end
        RUN: begin
          if (i_valid) begin
            crc_reg <= step_crc;
            cnt     <= cnt - ONE_L;
            if (cnt == ONE_L) begin
              if (mode) begin
                state <= CHECK;
              end else begin
                o_ready <= 1'b0;
                o_crc   <= step_crc;
                o_done  <= 1'b1;
                state   <= DONE;
              end
            end
          end
        end
        CHECK: begin
          if (i_valid) begin
            o_err   <= (i_data[WPOLY-2:0] != crc_reg);
            o_crc   <= crc_reg;
            o_ready <= 1'b0;
            o_done  <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          o_busy <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_crc_ctrl.sv
// Directed and randomized frames against an arithmetic CRC model; a single
// negedge process checks every o_done pulse against the expected result queue.

module tb_crc_ctrl;
  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_start = 1'b0;
  logic       i_mode = 1'b0;
  logic [2:0] i_poly = '0;
  logic [4:0] i_len = '0;
  logic [3:0] i_data = '0;
  logic       i_valid = 1'b0;
  logic       o_ready, o_busy, o_done, o_err;
  logic [1:0] o_crc;

  crc_ctrl #(.WCODE(4), .WPOLY(3), .MAXLEN(16)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_mode(i_mode),
    .i_poly(i_poly), .i_len(i_len), .i_data(i_data), .i_valid(i_valid),
    .o_ready(o_ready), .o_busy(o_busy), .o_crc(o_crc), .o_done(o_done),
    .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  int n_chk = 0;
  int n_fail = 0;
  int ncyc = 0;
  int last_done = -1;

  logic [1:0] q_crc[$];
  logic       q_err[$];
  int         q_cyc[$];

  logic [3:0] dat[16];
  logic [3:0] chk;

  task automatic check(input bit ok, input string name, input int act, input int exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // CRC step as polynomial long division: each set data bit d[i] folds poly<<i in.
  function automatic logic [1:0] model_step(input logic [3:0] d, input logic [1:0] c,
                                            input logic [2:0] p);
    int acc;
    acc = {26'd0, d, c};
    for (int i = 0; i < 4; i++) if (d[i]) acc = acc ^ (int'(p) << i);
    return acc[1:0];
  endfunction

  always @(negedge i_clk) begin
    ncyc++;
    if (i_rst_n && o_done) begin
      last_done = ncyc;
      if (q_crc.size() == 0) begin
        check(1'b0, "unexpected_done", 1, 0);
      end else begin
        logic [1:0] ec;
        logic       ee;
        int         ey;
        ec = q_crc.pop_front();
        ee = q_err.pop_front();
        ey = q_cyc.pop_front();
        check(o_crc == ec, "done_crc", o_crc, ec);
        check(o_err == ee, "done_err", o_err, ee);
        check(ncyc == ey, "done_cycle", ncyc, ey);
        check(o_ready == 1'b0, "ready_in_done", o_ready, 0);
        check(o_busy == 1'b1, "busy_in_done", o_busy, 1);
      end
    end
  end

  task automatic step_cycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send_beat(input logic [3:0] d, input int gap_fix, input int gap_rnd,
                           input bit noise);
    int g;
    g = gap_fix + ((gap_rnd > 0) ? int'($urandom_range(0, gap_rnd)) : 0);
    i_valid = 1'b0;
    repeat (g) begin
      i_data = 4'($urandom);
      if (noise) begin
        i_start = 1'b1;
        i_len   = 5'($urandom);
        i_poly  = 3'($urandom);
        i_mode  = 1'($urandom);
      end
      step_cycle();
    end
    check(o_ready == 1'b1, "ready_before_beat", o_ready, 1);
    i_start = noise;
    i_valid = 1'b1;
    i_data  = d;
    step_cycle();
    i_valid = 1'b0;
    i_start = 1'b0;
  endtask

  task automatic do_frame(input logic md, input logic [2:0] pl, input logic [4:0] ln,
                          input int gap_fix, input int gap_rnd, input bit noise);
    int         k;
    int         lat;
    bit         legal;
    logic [1:0] crc;
    logic       err;
    legal = (ln >= 1) && (ln <= 16);
    i_start = 1'b1;
    i_mode  = md;
    i_poly  = pl;
    i_len   = ln;
    i_valid = !legal;
    step_cycle();
    i_start = 1'b0;
    i_valid = 1'b0;
    k = ncyc;
    check(o_busy == 1'b1, "busy_after_start", o_busy, 1);
    check(o_ready == legal, "ready_after_start", o_ready, int'(legal));
    if (!legal) begin
      q_crc.push_back(2'b00); q_err.push_back(1'b1); q_cyc.push_back(k + 1);
      lat = 1;
    end else begin
      check(o_err == 1'b0, "err_cleared_on_start", o_err, 0);
      crc = 2'b00;
      for (int b = 0; b < int'(ln); b++) begin
        send_beat(dat[b], (b == 0) ? gap_fix : 0, gap_rnd, noise);
        crc = model_step(dat[b], crc, pl);
      end
      if (md) begin
        send_beat(chk, 0, gap_rnd, noise);
        err = (chk[1:0] != crc);
      end else begin
        err = 1'b0;
      end
      q_crc.push_back(crc); q_err.push_back(err); q_cyc.push_back(ncyc + 1);
      lat = int'(ln) + (md ? 2 : 1);
    end
    for (int t = 0; t < 200 && (q_crc.size() != 0 || o_busy); t++) step_cycle();
    if (q_crc.size() != 0 || o_busy) begin
      check(1'b0, "frame_timeout", q_crc.size(), 0);
      q_crc.delete(); q_err.delete(); q_cyc.delete();
    end
    if (gap_fix == 0 && gap_rnd == 0) check(last_done - k == lat, "latency", last_done - k, lat);
  endtask

  initial begin
    repeat (2) @(negedge i_clk);
    check(o_ready == 0, "rst_ready", o_ready, 0);
    check(o_busy == 0, "rst_busy", o_busy, 0);
    check(o_crc == 0, "rst_crc", o_crc, 0);
    check(o_done == 0, "rst_done", o_done, 0);
    check(o_err == 0, "rst_err", o_err, 0);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    step_cycle();

    dat[0] = 4'h1; dat[1] = 4'h2; dat[2] = 4'h2;
    do_frame(1'b0, 3'b111, 5'd1, 0, 0, 1'b0);
    check(o_crc == 2'b11, "prefix1_crc", o_crc, 3);
    do_frame(1'b0, 3'b111, 5'd2, 0, 0, 1'b0);
    check(o_crc == 2'b01, "prefix2_crc", o_crc, 1);
    do_frame(1'b0, 3'b111, 5'd3, 0, 0, 1'b0);
    check(o_crc == 2'b11, "gen3_crc", o_crc, 3);
    check(o_err == 1'b0, "gen3_err", o_err, 0);

    chk = 4'h3;
    do_frame(1'b1, 3'b111, 5'd3, 0, 0, 1'b0);
    check(o_err == 1'b0, "check_ok_err", o_err, 0);
    check(o_crc == 2'b11, "check_ok_crc", o_crc, 3);
    chk = 4'h1;
    do_frame(1'b1, 3'b111, 5'd3, 0, 0, 1'b0);
    check(o_err == 1'b1, "check_bad_err", o_err, 1);
    repeat (3) step_cycle();
    check(o_err == 1'b1, "err_hold", o_err, 1);
    check(o_crc == 2'b11, "crc_hold", o_crc, 3);

    dat[0] = 4'hA;
    do_frame(1'b0, 3'b111, 5'd1, 5, 0, 1'b0);
    check(o_crc == 2'b10, "single_A_crc", o_crc, 2);

    do_frame(1'b0, 3'b111, 5'd0, 0, 0, 1'b0);
    check(o_err == 1'b1, "len0_err", o_err, 1);
    do_frame(1'b0, 3'b111, 5'd17, 0, 0, 1'b0);
    check(o_crc == 2'b00, "len17_crc", o_crc, 0);
    step_cycle();
    check(o_ready == 1'b0, "illegal_no_ready", o_ready, 0);

    for (int b = 0; b < 16; b++) dat[b] = 4'h1;
    do_frame(1'b0, 3'b111, 5'd15, 0, 0, 1'b0);
    check(o_crc == 2'b11, "len15_crc", o_crc, 3);
    do_frame(1'b0, 3'b111, 5'd16, 0, 0, 1'b0);
    check(o_crc == 2'b00, "maxlen_crc", o_crc, 0);

    dat[0] = 4'h1; dat[1] = 4'h2; dat[2] = 4'h2;
    do_frame(1'b0, 3'b111, 5'd3, 0, 2, 1'b1);
    check(o_crc == 2'b11, "start_noise_crc", o_crc, 3);

    chk = 4'h1;
    do_frame(1'b1, 3'b111, 5'd3, 0, 0, 1'b0);
    i_start = 1'b1; i_mode = 1'b0; i_poly = 3'b111; i_len = 5'd3;
    step_cycle();
    i_start = 1'b0;
    send_beat(4'h1, 0, 0, 1'b0);
    send_beat(4'h2, 0, 0, 1'b0);
    i_rst_n = 1'b0;
    #2;
    check(o_busy == 0, "abort_busy", o_busy, 0);
    check(o_ready == 0, "abort_ready", o_ready, 0);
    check(o_crc == 0, "abort_crc", o_crc, 0);
    check(o_err == 0, "abort_err", o_err, 0);
    step_cycle();
    i_rst_n = 1'b1;
    step_cycle();
    do_frame(1'b0, 3'b111, 5'd3, 0, 0, 1'b0);
    check(o_crc == 2'b11, "post_reset_crc", o_crc, 3);

    for (int f = 0; f < 24; f++) begin
      logic [2:0] pl;
      logic [4:0] ln;
      logic       md;
      logic [1:0] c;
      pl = 3'($urandom);
      ln = 5'($urandom_range(1, 16));
      md = 1'($urandom);
      c  = 2'b00;
      for (int b = 0; b < 16; b++) dat[b] = 4'($urandom);
      for (int b = 0; b < int'(ln); b++) c = model_step(dat[b], c, pl);
      chk = {2'($urandom), ($urandom_range(0, 1) != 0) ? c : 2'($urandom)};
      do_frame(md, pl, ln, 0, 3, 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got %0d expected %0d", 1, 0);
    $fatal(1, "timeout");
  end
endmodule
